// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared 800x600@72 timing constants, coordinate type and helpers
package vga_pkg;

  // Coordinate and frame-divider widths
  localparam int CNT_W       = 11;
  localparam int FRAME_CNT_W = 8;

  typedef logic [CNT_W-1:0]       coord_t;
  typedef logic [FRAME_CNT_W-1:0] frame_cnt_t;

  // Horizontal timing in pixel clocks
  localparam int VGA_H_VISIBLE = 800;
  localparam int VGA_H_FRONT   = 56;
  localparam int VGA_H_SYNC    = 120;
  localparam int VGA_H_BACK    = 64;
  localparam int VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;

  // Vertical timing in lines
  localparam int VGA_V_VISIBLE = 600;
  localparam int VGA_V_FRONT   = 37;
  localparam int VGA_V_SYNC    = 6;
  localparam int VGA_V_BACK    = 23;
  localparam int VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  // Sync windows (inclusive) derived from the porches: hsync 856..975, vsync 637..642
  localparam int VGA_H_SYNC_LO = VGA_H_VISIBLE + VGA_H_FRONT;
  localparam int VGA_H_SYNC_HI = VGA_H_SYNC_LO + VGA_H_SYNC - 1;
  localparam int VGA_V_SYNC_LO = VGA_V_VISIBLE + VGA_V_FRONT;
  localparam int VGA_V_SYNC_HI = VGA_V_SYNC_LO + VGA_V_SYNC - 1;

  // A divider of 0 would never tick; clamp into the representable 1..255 range
  function automatic int frame_div_eff(input int div);
    if (div < 1) begin
      return 1;
    end
    if (div > 255) begin
      return 255;
    end
    return div;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - wrapping axis counter with carry-out and registered window decode
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int TOTAL  = VGA_H_TOTAL,
  parameter int WIN_LO = VGA_H_SYNC_LO,
  parameter int WIN_HI = VGA_H_SYNC_HI
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   advance,
  output coord_t count,
  output coord_t count_next,
  output logic   carry,
  output logic   win
);

  localparam coord_t LAST = coord_t'(TOTAL - 1);
  localparam coord_t LO   = coord_t'(WIN_LO);
  localparam coord_t HI   = coord_t'(WIN_HI);

  logic at_last;

  // Next-state count and carry; carry fires on the cycle the counter wraps to 0
  always_comb begin
    at_last    = (count == LAST);
    carry      = advance && at_last;
    count_next = count;
    if (advance) begin
      count_next = at_last ? '0 : count + coord_t'(1);
    end
  end

  // Reset parks the count on its last value so the first live edge lands on 0;
  // the window flag is decoded from the next count so it lines up with count
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= LAST;
      win   <= 1'b0;
    end else begin
      count <= count_next;
      win   <= (count_next >= LO) && (count_next <= HI);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing, decodes and per-N-frame motion tick
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = VGA_H_VISIBLE,
  parameter int H_FRONT   = VGA_H_FRONT,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BACK    = VGA_H_BACK,
  parameter int V_VISIBLE = VGA_V_VISIBLE,
  parameter int V_FRONT   = VGA_V_FRONT,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BACK    = VGA_V_BACK,
  parameter int FRAME_DIV = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         pause,
  output logic [10:0]  X,
  output logic [10:0]  Y,
  output logic         hsync,
  output logic         vsync,
  output logic         video_on,
  output logic         frame_start,
  output logic         enable
);

  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int H_SYNC_LO = H_VISIBLE + H_FRONT;
  localparam int H_SYNC_HI = H_SYNC_LO + H_SYNC - 1;
  localparam int V_SYNC_LO = V_VISIBLE + V_FRONT;
  localparam int V_SYNC_HI = V_SYNC_LO + V_SYNC - 1;

  localparam coord_t     H_VIS_LAST = coord_t'(H_VISIBLE - 1);
  localparam coord_t     V_VIS_LAST = coord_t'(V_VISIBLE - 1);
  localparam coord_t     V_TICK     = coord_t'(V_VISIBLE);
  localparam int         DIV_EFF    = frame_div_eff(FRAME_DIV);
  localparam frame_cnt_t DIV_LAST   = frame_cnt_t'(DIV_EFF - 1);

  coord_t     h_count;
  coord_t     h_next;
  coord_t     v_count;
  coord_t     v_next;
  logic       h_carry;
  logic       v_carry;
  logic       h_win;
  logic       v_win;
  logic       video_next;
  logic       tick_point;
  frame_cnt_t frame_cnt;

  vga_axis_counter #(
    .TOTAL  (H_TOTAL),
    .WIN_LO (H_SYNC_LO),
    .WIN_HI (H_SYNC_HI)
  ) u_hcnt (
    .clk        (clk),
    .reset      (reset),
    .advance    (1'b1),
    .count      (h_count),
    .count_next (h_next),
    .carry      (h_carry),
    .win        (h_win)
  );

  vga_axis_counter #(
    .TOTAL  (V_TOTAL),
    .WIN_LO (V_SYNC_LO),
    .WIN_HI (V_SYNC_HI)
  ) u_vcnt (
    .clk        (clk),
    .reset      (reset),
    .advance    (h_carry),
    .count      (v_count),
    .count_next (v_next),
    .carry      (v_carry),
    .win        (v_win)
  );

  assign X     = h_count;
  assign Y     = v_count;
  assign hsync = h_win;
  assign vsync = v_win;

  // Decodes of the next raster position so registered flags align with X/Y
  always_comb begin
    video_next = (h_next <= H_VIS_LAST) && (v_next <= V_VIS_LAST);
    tick_point = (h_next == '0) && (v_next == V_TICK);
  end

  // Active-video and frame-start flags; a vertical carry means the raster
  // is about to land on (0,0)
  always_ff @(posedge clk) begin
    if (reset) begin
      video_on    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      video_on    <= video_next;
      frame_start <= v_carry;
    end
  end

  // Frame divider: tick once every DIV_EFF unpaused tick points on the first
  // blanked line, so sprites move only while the screen is dark
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt <= '0;
      enable    <= 1'b0;
    end else begin
      enable <= 1'b0;
      if (tick_point && !pause) begin
        if (frame_cnt == DIV_LAST) begin
          frame_cnt <= '0;
          enable    <= 1'b1;
        end else begin
          frame_cnt <= frame_cnt + frame_cnt_t'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic reset_s;
  logic pause_d;
  logic pause_s2;

  logic [10:0] x_d, y_d, x_3, y_3, x_2, y_2;
  logic hs_d, vs_d, vo_d, fs_d, en_d;
  logic hs_3, vs_3, vo_3, fs_3, en_3;
  logic hs_2, vs_2, vo_2, fs_2, en_2;

  int compared = 0;
  int mismatched = 0;

  vga_timing_gen dut (
    .clk(clk), .reset(reset), .pause(pause_d),
    .X(x_d), .Y(y_d), .hsync(hs_d), .vsync(vs_d),
    .video_on(vo_d), .frame_start(fs_d), .enable(en_d)
  );

  // Shrunk raster: 15 clocks/line (hsync 10..12), 11 lines/frame (vsync 8..9), 165 clocks/frame
  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(1), .FRAME_DIV(3)
  ) dut_s3 (
    .clk(clk), .reset(reset_s), .pause(1'b0),
    .X(x_3), .Y(y_3), .hsync(hs_3), .vsync(vs_3),
    .video_on(vo_3), .frame_start(fs_3), .enable(en_3)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(1), .FRAME_DIV(2)
  ) dut_s2 (
    .clk(clk), .reset(reset_s), .pause(pause_s2),
    .X(x_2), .Y(y_2), .hsync(hs_2), .vsync(vs_2),
    .video_on(vo_2), .frame_start(fs_2), .enable(en_2)
  );

  task automatic test_reset();
    reset = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    compared++;
    if (x_d !== 11'd1039 || y_d !== 11'd665) begin
      mismatched++;
      $display("FAIL reset_xy: got X=%0d Y=%0d want X=1039 Y=665", x_d, y_d);
    end
    compared++;
    if ({hs_d, vs_d, vo_d, fs_d, en_d} !== 5'b00000) begin
      mismatched++;
      $display("FAIL reset_flags: got hs,vs,vo,fs,en=%b want 00000", {hs_d, vs_d, vo_d, fs_d, en_d});
    end
    reset = 1'b0;
    @(negedge clk);
    compared++;
    if (x_d !== 11'd0 || y_d !== 11'd0) begin
      mismatched++;
      $display("FAIL first_xy: got X=%0d Y=%0d want X=0 Y=0", x_d, y_d);
    end
    compared++;
    if ({hs_d, vs_d, vo_d, fs_d, en_d} !== 5'b00110) begin
      mismatched++;
      $display("FAIL first_flags: got hs,vs,vo,fs,en=%b want 00110", {hs_d, vs_d, vo_d, fs_d, en_d});
    end
    @(negedge clk);
    compared++;
    if (x_d !== 11'd1 || y_d !== 11'd0 || fs_d !== 1'b0) begin
      mismatched++;
      $display("FAIL second_cycle: got X=%0d Y=%0d fs=%b want X=1 Y=0 fs=0", x_d, y_d, fs_d);
    end
  endtask

  // Starts at (1,0) and runs one full line to (1,1)
  task automatic test_line();
    int ex = 1;
    int ey = 0;
    int bad = 0;
    int hs_cnt = 0;
    int rise_x = -1;
    int fall_x = -1;
    int vfall_x = -1;
    int ystep_x = -1;
    int ystep_y = -1;
    logic prev_hs = hs_d;
    logic prev_vo = vo_d;
    logic [10:0] prev_y = y_d;
    for (int k = 0; k < 1040; k++) begin
      @(negedge clk);
      ex++;
      if (ex == 1040) begin
        ex = 0;
        ey++;
      end
      if (x_d !== 11'(ex) || y_d !== 11'(ey) ||
          vo_d !== ((ex < 800) && (ey < 600)) ||
          hs_d !== ((ex >= 856) && (ex <= 975))) begin
        bad++;
      end
      if (hs_d && !prev_hs) rise_x = int'(x_d);
      if (!hs_d && prev_hs) fall_x = int'(x_d);
      if (!vo_d && prev_vo) vfall_x = int'(x_d);
      if (y_d != prev_y) begin
        ystep_x = int'(x_d);
        ystep_y = int'(y_d);
      end
      if (hs_d) hs_cnt++;
      prev_hs = hs_d;
      prev_vo = vo_d;
      prev_y = y_d;
    end
    compared++;
    if (bad != 0) begin
      mismatched++;
      $display("FAIL line_track: got %0d bad cycles want 0", bad);
    end
    compared++;
    if (rise_x != 856 || fall_x != 976) begin
      mismatched++;
      $display("FAIL hsync_edges: got rise X=%0d fall X=%0d want 856 976", rise_x, fall_x);
    end
    compared++;
    if (hs_cnt != 120) begin
      mismatched++;
      $display("FAIL hsync_width: got %0d want 120", hs_cnt);
    end
    compared++;
    if (vfall_x != 800) begin
      mismatched++;
      $display("FAIL video_fall: got X=%0d want 800", vfall_x);
    end
    compared++;
    if (ystep_x != 0 || ystep_y != 1) begin
      mismatched++;
      $display("FAIL y_step: got X=%0d Y=%0d want X=0 Y=1", ystep_x, ystep_y);
    end
  endtask

  task automatic test_mid_reset();
    repeat (399) @(negedge clk);
    compared++;
    if (x_d !== 11'd400 || y_d !== 11'd1) begin
      mismatched++;
      $display("FAIL pre_reset_pos: got X=%0d Y=%0d want X=400 Y=1", x_d, y_d);
    end
    reset = 1'b1;
    @(negedge clk);
    compared++;
    if (x_d !== 11'd1039 || y_d !== 11'd665 || {hs_d, vs_d, vo_d, fs_d, en_d} !== 5'b00000) begin
      mismatched++;
      $display("FAIL mid_reset: got X=%0d Y=%0d flags=%b want X=1039 Y=665 flags=00000",
               x_d, y_d, {hs_d, vs_d, vo_d, fs_d, en_d});
    end
    reset = 1'b0;
    @(negedge clk);
    compared++;
    if (x_d !== 11'd0 || y_d !== 11'd0 || fs_d !== 1'b1 || vo_d !== 1'b1) begin
      mismatched++;
      $display("FAIL mid_reset_resume: got X=%0d Y=%0d fs=%b vo=%b want 0 0 1 1", x_d, y_d, fs_d, vo_d);
    end
  endtask

  // FRAME_DIV=3 over 9 shrunk frames; ticks expected at cycle 165k+90 for k=2,5,8
  task automatic test_frame_div3();
    int bad = 0;
    int en_cnt = 0;
    int en_bad = 0;
    int en_vo_bad = 0;
    int vs_cnt = 0;
    int fs_cnt = 0;
    int vs_first = -1;
    reset_s = 1'b1;
    repeat (3) @(negedge clk);
    reset_s = 1'b0;
    for (int c = 0; c < 9 * 165; c++) begin
      int ex;
      int ey;
      logic en_exp;
      @(negedge clk);
      ex = c % 15;
      ey = (c / 15) % 11;
      en_exp = ((c % 165) == 90) && (((c / 165) % 3) == 2);
      if (x_3 !== 11'(ex) || y_3 !== 11'(ey) ||
          vo_3 !== ((ex < 8) && (ey < 6)) ||
          hs_3 !== ((ex >= 10) && (ex <= 12)) ||
          vs_3 !== ((ey >= 8) && (ey <= 9)) ||
          fs_3 !== ((c % 165) == 0)) begin
        bad++;
      end
      if (en_3 !== en_exp) en_bad++;
      if (en_3 === 1'b1) begin
        en_cnt++;
        if (vo_3 !== 1'b0 || x_3 !== 11'd0 || y_3 !== 11'd6) en_vo_bad++;
      end
      if (c < 165 && vs_3 === 1'b1) begin
        vs_cnt++;
        if (vs_first < 0) vs_first = int'(y_3) * 15 + int'(x_3);
      end
      if (fs_3 === 1'b1) fs_cnt++;
    end
    compared++;
    if (bad != 0) begin
      mismatched++;
      $display("FAIL frame_track: got %0d bad cycles want 0", bad);
    end
    compared++;
    if (en_cnt != 3) begin
      mismatched++;
      $display("FAIL div3_count: got %0d enable pulses want 3", en_cnt);
    end
    compared++;
    if (en_bad != 0) begin
      mismatched++;
      $display("FAIL div3_timing: got %0d misplaced enable cycles want 0", en_bad);
    end
    compared++;
    if (en_vo_bad != 0) begin
      mismatched++;
      $display("FAIL div3_blank: got %0d pulses off (0,6) or in video want 0", en_vo_bad);
    end
    compared++;
    if (vs_cnt != 30 || vs_first != 120) begin
      mismatched++;
      $display("FAIL vsync_window: got %0d cycles starting at pos %0d want 30 at 120", vs_cnt, vs_first);
    end
    compared++;
    if (fs_cnt != 9) begin
      mismatched++;
      $display("FAIL frame_start_count: got %0d want 9", fs_cnt);
    end
  endtask

  // FRAME_DIV=2 with pause held over the second tick point (cycle 255)
  task automatic test_pause();
    int bad = 0;
    int en_bad = 0;
    reset_s = 1'b1;
    pause_s2 = 1'b0;
    repeat (3) @(negedge clk);
    reset_s = 1'b0;
    for (int c = 0; c < 5 * 165; c++) begin
      int ex;
      int ey;
      logic en_exp;
      @(negedge clk);
      ex = c % 15;
      ey = (c / 15) % 11;
      en_exp = (c == 420) || (c == 750);
      if (x_2 !== 11'(ex) || y_2 !== 11'(ey) ||
          vo_2 !== ((ex < 8) && (ey < 6)) ||
          hs_2 !== ((ex >= 10) && (ex <= 12)) ||
          vs_2 !== ((ey >= 8) && (ey <= 9)) ||
          fs_2 !== ((c % 165) == 0)) begin
        bad++;
      end
      if (en_2 !== en_exp) en_bad++;
      if (c == 250 || c == 300) begin
        compared++;
        if (dut_s2.frame_cnt !== 8'd1) begin
          mismatched++;
          $display("FAIL pause_hold_cnt: at cycle %0d got frame_cnt=%0d want 1", c, dut_s2.frame_cnt);
        end
      end
      if (c == 450) begin
        compared++;
        if (dut_s2.frame_cnt !== 8'd0) begin
          mismatched++;
          $display("FAIL post_tick_cnt: got frame_cnt=%0d want 0", dut_s2.frame_cnt);
        end
      end
      if (c == 200) pause_s2 = 1'b1;
      if (c == 300) pause_s2 = 1'b0;
    end
    compared++;
    if (bad != 0) begin
      mismatched++;
      $display("FAIL pause_transparent: got %0d bad cycles want 0", bad);
    end
    compared++;
    if (en_bad != 0) begin
      mismatched++;
      $display("FAIL pause_enable: got %0d misplaced enable cycles want 0 (pulses at 420,750)", en_bad);
    end
  endtask

  initial begin
    reset = 1'b1;
    reset_s = 1'b1;
    pause_d = 1'b0;
    pause_s2 = 1'b0;
    test_reset();
    test_line();
    test_mid_reset();
    test_frame_div3();
    test_pause();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
